// File: rtl/rx_controller.sv
// rx_controller: sequences UART frontend frames into a first-word-fall-through RX FIFO with status flags and IRQ.
// Optional macro RX_TIMEOUT_EN adds an idle-timeout counter and the rto_o output.
module rx_controller #(
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_WIDTH      = $clog2(FIFO_DEPTH) + 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cr_ds_i,
    input  logic [10:0]          fe_frame_i,
    input  logic                 fe_parity_err_i,
    input  logic                 fe_frame_err_i,
    input  logic                 fe_valid_i,
    input  logic                 rd_i,
    input  logic                 ore_clr_i,
    input  logic                 rxneie_i,
    input  logic                 errie_i,
    output logic [7:0]           rd_data_o,
    output logic                 rxne_o,
    output logic                 rxfull_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 pe_o,
    output logic                 fe_o,
    output logic                 ore_o,
`ifdef RX_TIMEOUT_EN
    output logic                 rto_o,
`endif
    output logic                 irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    state_t               state_q;
    logic [7:0]           frame_q;
    logic                 pe_q, fe_q, ore_q;
    logic [9:0]           entry_q;
    logic [CNT_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [9:0]           mem_q [FIFO_DEPTH];
    logic [9:0]           head;
    logic                 empty, full, push, pop, ovf, rto;
    logic                 unused_frame_bits;

    assign unused_frame_bits = ^fe_frame_i[10:8];
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty   = count_o == '0;
    assign full    = count_o == DEPTH_C;
    assign pop     = rd_i & ~empty;
    // A pop in the commit cycle frees a slot, so a full FIFO still accepts the frame.
    assign push    = (state_q == COMMIT) & (~full | pop);
    assign ovf     = ((state_q == COMMIT) & ~push) | (fe_valid_i & (state_q != IDLE));
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            entry_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ore_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (fe_valid_i) begin
                    frame_q <= fe_frame_i[7:0];
                    pe_q    <= fe_parity_err_i;
                    fe_q    <= fe_frame_err_i;
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    entry_q <= {fe_q, pe_q, cr_ds_i ? frame_q : {1'b0, frame_q[6:0]}};
                    state_q <= COMMIT;
                end
                default: state_q <= IDLE;
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + ONE_C;
            if (pop) rd_ptr_q <= rd_ptr_q + ONE_C;
            ore_q <= ovf | (ore_q & ~ore_clr_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_q;
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX_C = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) to_cnt_q <= '0;
        else if (push | pop | empty) to_cnt_q <= '0;
        else if (to_cnt_q != TMAX_C) to_cnt_q <= to_cnt_q + TW'(1);
    end

    assign rto   = (to_cnt_q == TMAX_C) & ~empty;
    assign rto_o = rto;
`else
    assign rto = 1'b0;
`endif

    assign rxne_o    = ~empty;
    assign rxfull_o  = full;
    assign rd_data_o = empty ? 8'h00 : head[7:0];
    assign pe_o      = ~empty & head[8];
    assign fe_o      = ~empty & head[9];
    assign ore_o     = ore_q;
    assign irq_o     = (rxneie_i & (rxne_o | rto)) | (errie_i & (pe_o | fe_o | ore_o));
endmodule

// File: doc/rx_controller.md
Name: rx_controller

Overview:
Sequences frames delivered by the UART receive frontend into a receive FIFO and maintains the RX status flags read by the Wishbone register bank. Each single-cycle frontend valid pulse is captured, the data byte is extracted per the data-size configuration, and the byte is committed together with its per-frame error bits. The block also detects overrun, raises the RX interrupt request and provides first-word-fall-through read data to the register bank.

Parameters:
FIFO_DEPTH, 4, number of entries; power of two, >= 2
CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of occupancy count
TIMEOUT_CYCLES, 1024, idle-timeout threshold in clk_i cycles (used only with RX_TIMEOUT_EN)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active-low
cr_ds_i  input  1  data size: 1 = 8 bits, 0 = 7 bits
fe_frame_i  input  11  aligned frame from frontend; bit0 = first data bit
fe_parity_err_i  input  1  frontend parity error, qualified by fe_valid_i
fe_frame_err_i  input  1  frontend stop-bit error, qualified by fe_valid_i
fe_valid_i  input  1  single-cycle frame-complete pulse
rd_i  input  1  single-cycle pop request from register bank (RXDR read)
ore_clr_i  input  1  clears sticky overrun flag
rxneie_i  input  1  interrupt enable, RX not empty
errie_i  input  1  interrupt enable, error (pe/fe/ore)
rd_data_o  output  8  head entry data; 0 when empty
rxne_o  output  1  FIFO not empty
rxfull_o  output  1  FIFO full
count_o  output  CNT_WIDTH  occupancy
pe_o  output  1  parity error of head entry
fe_o  output  1  frame error of head entry
ore_o  output  1  sticky overrun
irq_o  output  1  interrupt request

Behaviour:
- Reset (rst_ni low, asynchronous): FSM = IDLE; pointers/count = 0; ore = 0; all outputs 0.
- FIFO entry = {fe, pe, data[7:0]}; data = cr_ds_i ? fe_frame_i[7:0] : {1'b0, fe_frame_i[6:0]}. cr_ds_i is sampled in CAPTURE.
- FSM IDLE: fe_valid_i=1 -> register fe_frame_i and both error bits, go to CAPTURE.
- CAPTURE: build entry -> COMMIT.
- COMMIT: if (!full || rd_i pop this cycle) write entry at wr_ptr, wr_ptr++; else drop frame, set ore. -> IDLE.
- Latency: fe_valid_i in cycle N -> rxne_o/rd_data_o valid in cycle N+3.
- fe_valid_i while in CAPTURE or COMMIT: frame dropped, ore set (cannot occur at legal baud rates; defined for robustness).
- rd_i with rxne_o=1: rd_ptr++ at clock edge. rd_i when empty: ignored, no state change.
- Simultaneous push and pop: both happen, count unchanged. Pop from full plus push: push accepted, no overrun.
- Pointers are CNT_WIDTH wide and wrap modulo 2*FIFO_DEPTH. full = count == FIFO_DEPTH.
- rd_data_o, pe_o and fe_o come combinationally from the head entry and are gated to 0 when empty.
- ore: sticky; set by overrun, cleared by ore_clr_i. A simultaneous set and clear leaves ore = 1.
- irq_o = (rxneie_i & rxne_o) | (errie_i & (pe_o | fe_o | ore_o)); combinational from registered state.

Optional Feature:
RX_TIMEOUT_EN:
- Defined: adds output rto_o (1 bit) and a timeout counter.
- Counter clears on every commit, every pop, or when the FIFO is empty; otherwise it increments, saturating at TIMEOUT_CYCLES.
- rto_o = 1 when the counter == TIMEOUT_CYCLES and rxne_o = 1. rto_o is ORed into irq_o, gated by rxneie_i.
- Undefined: no counter, no rto_o port; irq_o as above.

Test Plan:
- Reset mid-frame: pulse fe_valid_i, drop rst_ni in CAPTURE -> all outputs 0 immediately; the next frame, 0x5A, is read correctly.
- 8-bit: cr_ds_i=1, fe_frame_i=0x6A5, one pulse -> 3 cycles later rxne_o=1, rd_data_o=0xA5, count_o=1; rd_i -> rxne_o=0, rd_data_o=0.
- 7-bit: cr_ds_i=0, fe_frame_i=0x0FF, fe_parity_err_i=1 -> rd_data_o=0x7F, pe_o=1, irq_o=1 with errie_i=1.
- Overrun: push 5 frames 0x01..0x05 with FIFO_DEPTH=4, no reads -> rxfull_o=1, ore_o=1, pops return 0x01..0x04. Then ore_clr_i -> ore_o=0.
- Full plus pop: FIFO full, rd_i asserted in the COMMIT cycle of 0x99 -> ore_o stays 0, count_o stays 4, 0x99 is last out.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: one frame, no reads -> rto_o rises 16 cycles after commit; rd_i -> rto_o=0.
